ext_spike_router: RTL and testbench

- Merges external stimulus spikes and neuron output spikes into one spike stream per synapse row.
- Sits between the testbench stimulus source / neuron columns and the synapse-row inputs of the neural-network array.
- External stimulus always has priority.
- Neuron spikes are rising-edge detected, broadcast to every row, buffered per row/column and drained one per cycle per row.

---
 rtl/ext_spike_router_if.sv | 24 ++
 rtl/ext_spike_router.sv | 93 +++++++++
 tb/tb_ext_spike_router.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/ext_spike_router_if.sv
// Spike router bus: neuron levels and external stimulus in, merged per-row
// spike stream and sticky overflow out.
interface ext_spike_router_if #(
  parameter int NUM_SYNAPSE_ROWS = 2,
  parameter int NUM_COLS         = 2,
  parameter int ADDR_WIDTH       = 6
);
  logic [NUM_COLS-1:0]                    spike_input;
  logic [NUM_SYNAPSE_ROWS-1:0]            ext_valid;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] ext_addr;
  logic [NUM_SYNAPSE_ROWS-1:0]            out_valid;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0] out_addr;
  logic                                   overflow;

  modport master (
    output spike_input, ext_valid, ext_addr,
    input  out_valid, out_addr, overflow
  );

  modport slave (
    input  spike_input, ext_valid, ext_addr,
    output out_valid, out_addr, overflow
  );
endinterface

// File: rtl/ext_spike_router.sv
// Merges external stimulus and edge-detected neuron spikes into one spike
// stream per synapse row; external stimulus wins, neuron spikes queue per row.
module ext_spike_router #(
  parameter int NUM_SYNAPSE_ROWS = 2,
  parameter int NUM_COLS         = 2,
  parameter int ADDR_WIDTH       = 6,
  parameter int NEURON_ADDR_BASE = 0
) (
  input  logic               clk,
  input  logic               reset,
  ext_spike_router_if.slave  bus
);

  logic [NUM_COLS-1:0]                        spike_prev;
  logic [NUM_COLS-1:0]                        spike_event;
  logic [NUM_SYNAPSE_ROWS-1:0][NUM_COLS-1:0]  pending;
  logic [NUM_SYNAPSE_ROWS-1:0][NUM_COLS-1:0]  pending_nxt;
  logic [NUM_SYNAPSE_ROWS-1:0][NUM_COLS-1:0]  cand;
  logic [NUM_SYNAPSE_ROWS-1:0][NUM_COLS-1:0]  grant;
  logic [NUM_COLS-1:0]                        pending_any;
  logic [NUM_SYNAPSE_ROWS-1:0]                valid_q;
  logic [NUM_SYNAPSE_ROWS-1:0]                valid_nxt;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0]     addr_q;
  logic [NUM_SYNAPSE_ROWS*ADDR_WIDTH-1:0]     addr_nxt;
  logic                                       overflow_q;
  logic                                       merge;

  assign spike_event = bus.spike_input & ~spike_prev;

  // A new event landing on a column still pending in any row collapses two
  // spikes into one delivery, including the cycle that bit is being granted.
  always_comb begin
    pending_any = '0;
    for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
      pending_any = pending_any | pending[r];
    end
  end

  assign merge = |(spike_event & pending_any);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch can be inferred.
  always_comb begin
    cand        = '0;
    grant       = '0;
    pending_nxt = '0;
    valid_nxt   = '0;
    addr_nxt    = '0;
    for (int r = 0; r < NUM_SYNAPSE_ROWS; r++) begin
      cand[r]        = pending[r] | spike_event;
      pending_nxt[r] = cand[r];
      if (bus.ext_valid[r]) begin
        valid_nxt[r]                         = 1'b1;
        addr_nxt[r*ADDR_WIDTH +: ADDR_WIDTH] = bus.ext_addr[r*ADDR_WIDTH +: ADDR_WIDTH];
      end else if (|cand[r]) begin
        // Isolate the lowest set bit: ascending column index wins.
        grant[r]       = cand[r] & (~cand[r] + NUM_COLS'(1));
        pending_nxt[r] = cand[r] & ~grant[r];
        valid_nxt[r]   = 1'b1;
        for (int c = 0; c < NUM_COLS; c++) begin
          if (grant[r][c]) begin
            addr_nxt[r*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(NEURON_ADDR_BASE + c);
          end
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the pending matrix is a small flop array, not RAM, so it is
      // reset with everything else; queued spikes must not survive a reset.
      spike_prev <= '0;
      pending    <= '0;
      valid_q    <= '0;
      addr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      spike_prev <= bus.spike_input;
      pending    <= pending_nxt;
      valid_q    <= valid_nxt;
      addr_q     <= addr_nxt;
      overflow_q <= overflow_q | merge;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_addr  = addr_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_ext_spike_router.sv
// Self-checking bench for ext_spike_router: directed vector table, reset
// corner cases, then random traffic against a queue-level reference model.
module tb_ext_spike_router;

  localparam int NR   = 2;
  localparam int NC   = 2;
  localparam int AW   = 6;
  localparam int BASE = 0;

  logic clk;
  logic reset;

  ext_spike_router_if #(.NUM_SYNAPSE_ROWS(NR), .NUM_COLS(NC), .ADDR_WIDTH(AW)) bus ();

  ext_spike_router #(
    .NUM_SYNAPSE_ROWS(NR),
    .NUM_COLS        (NC),
    .ADDR_WIDTH      (AW),
    .NEURON_ADDR_BASE(BASE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per row a set of columns waiting for delivery.
  bit                m_prev [NC];
  bit                m_pend [NR][NC];
  bit                m_ovf;
  logic [NR-1:0]     m_valid;
  logic [NR*AW-1:0]  m_addr;

  task automatic model_reset();
    for (int c = 0; c < NC; c++) m_prev[c] = 1'b0;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < NC; c++) m_pend[r][c] = 1'b0;
    m_ovf   = 1'b0;
    m_valid = '0;
    m_addr  = '0;
  endtask

  task automatic model_step(input logic [NC-1:0] sp, input logic [NR-1:0] ev,
                            input logic [NR*AW-1:0] ea);
    bit rise [NC];
    for (int c = 0; c < NC; c++) rise[c] = sp[c] && !m_prev[c];
    for (int c = 0; c < NC; c++)
      for (int r = 0; r < NR; r++)
        if (rise[c] && m_pend[r][c]) m_ovf = 1'b1;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) if (rise[c]) m_pend[r][c] = 1'b1;
      m_valid[r]            = 1'b0;
      m_addr[r*AW +: AW]    = '0;
      if (ev[r]) begin
        m_valid[r]         = 1'b1;
        m_addr[r*AW +: AW] = ea[r*AW +: AW];
      end else begin
        for (int c = 0; c < NC; c++) begin
          if (m_pend[r][c]) begin
            m_valid[r]         = 1'b1;
            m_addr[r*AW +: AW] = AW'(BASE + c);
            m_pend[r][c]       = 1'b0;
            break;
          end
        end
      end
    end
    for (int c = 0; c < NC; c++) m_prev[c] = sp[c];
  endtask

  // Drive inputs, clock once, sample #1 after the edge, advance the model.
  task automatic drive_cycle(input logic [NC-1:0] sp, input logic [NR-1:0] ev,
                             input logic [NR*AW-1:0] ea);
    bus.spike_input = sp;
    bus.ext_valid   = ev;
    bus.ext_addr    = ea;
    @(posedge clk);
    #1;
    model_step(sp, ev, ea);
  endtask

  typedef struct {
    logic [NC-1:0]    sp;
    logic [NR-1:0]    ev;
    logic [NR*AW-1:0] ea;
    logic [NR-1:0]    exp_valid;
    logic [NR*AW-1:0] exp_addr;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [20];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Directed vectors; row1 address sits in bits [11:6], row0 in [5:0].
    vecs[0]  = '{2'b00, 2'b01, 12'h005, 2'b01, 12'h005, 1'b0}; // ext row0 addr 5
    vecs[1]  = '{2'b00, 2'b00, 12'h000, 2'b00, 12'h000, 1'b0};
    vecs[2]  = '{2'b10, 2'b00, 12'h000, 2'b11, 12'h041, 1'b0}; // col1 rises
    vecs[3]  = '{2'b10, 2'b00, 12'h000, 2'b00, 12'h000, 1'b0}; // held: no repeat
    vecs[4]  = '{2'b00, 2'b00, 12'h000, 2'b00, 12'h000, 1'b0};
    vecs[5]  = '{2'b11, 2'b00, 12'h000, 2'b11, 12'h000, 1'b0}; // both rise: col0
    vecs[6]  = '{2'b11, 2'b00, 12'h000, 2'b11, 12'h041, 1'b0}; // then col1
    vecs[7]  = '{2'b11, 2'b00, 12'h000, 2'b00, 12'h000, 1'b0};
    vecs[8]  = '{2'b00, 2'b00, 12'h000, 2'b00, 12'h000, 1'b0};
    vecs[9]  = '{2'b01, 2'b01, 12'h002, 2'b11, 12'h002, 1'b0}; // row0 blocked
    vecs[10] = '{2'b01, 2'b01, 12'h002, 2'b01, 12'h002, 1'b0};
    vecs[11] = '{2'b01, 2'b01, 12'h002, 2'b01, 12'h002, 1'b0};
    vecs[12] = '{2'b01, 2'b00, 12'h000, 2'b01, 12'h000, 1'b0}; // drained late
    vecs[13] = '{2'b00, 2'b00, 12'h000, 2'b00, 12'h000, 1'b0};
    vecs[14] = '{2'b01, 2'b01, 12'h003, 2'b11, 12'h003, 1'b0}; // first edge
    vecs[15] = '{2'b00, 2'b01, 12'h003, 2'b01, 12'h003, 1'b0};
    vecs[16] = '{2'b01, 2'b01, 12'h003, 2'b11, 12'h003, 1'b1}; // second edge merges
    vecs[17] = '{2'b01, 2'b01, 12'h003, 2'b01, 12'h003, 1'b1};
    vecs[18] = '{2'b01, 2'b00, 12'h000, 2'b01, 12'h000, 1'b1}; // single delivery
    vecs[19] = '{2'b00, 2'b00, 12'h000, 2'b00, 12'h000, 1'b1}; // sticky

    reset           = 1'b1;
    bus.spike_input = '0;
    bus.ext_valid   = '0;
    bus.ext_addr    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset out_valid", 64'(bus.out_valid), 64'(0));
    check("reset out_addr",  64'(bus.out_addr),  64'(0));
    check("reset overflow",  64'(bus.overflow),  64'(0));
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      drive_cycle(vecs[i].sp, vecs[i].ev, vecs[i].ea);
      check($sformatf("vec%0d out_valid", i), 64'(bus.out_valid), 64'(vecs[i].exp_valid));
      check($sformatf("vec%0d out_addr", i),  64'(bus.out_addr),  64'(vecs[i].exp_addr));
      check($sformatf("vec%0d overflow", i),  64'(bus.overflow),  64'(vecs[i].exp_ovf));
    end

    // Reset while both rows hold pending spikes: outputs clear asynchronously.
    drive_cycle(2'b11, 2'b11, 12'h187);
    drive_cycle(2'b11, 2'b11, 12'h187);
    check("blocked out_valid", 64'(bus.out_valid), 64'(2'b11));
    check("blocked out_addr",  64'(bus.out_addr),  64'(12'h187));
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check("async reset out_valid", 64'(bus.out_valid), 64'(0));
    check("async reset out_addr",  64'(bus.out_addr),  64'(0));
    check("async reset overflow",  64'(bus.overflow),  64'(0));
    bus.spike_input = '0;
    bus.ext_valid   = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(2'b00, 2'b00, 12'h000);
      check($sformatf("post reset %0d out_valid", i), 64'(bus.out_valid), 64'(0));
      check($sformatf("post reset %0d overflow", i),  64'(bus.overflow),  64'(0));
    end

    // A level held high through reset release is one event.
    reset           = 1'b1;
    bus.spike_input = 2'b01;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    drive_cycle(2'b01, 2'b00, 12'h000);
    check("held level out_valid", 64'(bus.out_valid), 64'(2'b11));
    check("held level out_addr",  64'(bus.out_addr),  64'(12'h000));
    drive_cycle(2'b01, 2'b00, 12'h000);
    check("held level once", 64'(bus.out_valid), 64'(2'b00));

    // Random traffic against the model, with periodic resets.
    for (int blk = 0; blk < 4; blk++) begin
      reset = 1'b1;
      model_reset();
      #1;
      check($sformatf("rand blk%0d reset valid", blk), 64'(bus.out_valid), 64'(0));
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 150; i++) begin
        logic [NC-1:0]    sp;
        logic [NR-1:0]    ev;
        logic [NR*AW-1:0] ea;
        sp = NC'($urandom);
        ev = NR'($urandom) & NR'($urandom) & ((blk == 0) ? NR'(0) : NR'($urandom_range(0, 3)));
        ea = (NR*AW)'($urandom);
        drive_cycle(sp, ev, ea);
        check($sformatf("rand %0d.%0d out_valid", blk, i), 64'(bus.out_valid), 64'(m_valid));
        check($sformatf("rand %0d.%0d out_addr", blk, i),  64'(bus.out_addr),  64'(m_addr));
        check($sformatf("rand %0d.%0d overflow", blk, i),  64'(bus.overflow),  64'(m_ovf));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
